// File: rtl/dram_phase_sequencer_pkg.sv
// Phase encoding shared by the DRAM phase sequencer, its interface and the bench.
package dram_seq_pkg;
  localparam int PHASE_W = 3;

  localparam logic [PHASE_W-1:0] PHASE_IDLE  = 3'd0;
  localparam logic [PHASE_W-1:0] PHASE_LOAD  = 3'd1;
  localparam logic [PHASE_W-1:0] PHASE_RUN   = 3'd2;
  localparam logic [PHASE_W-1:0] PHASE_DRAIN = 3'd3;
  localparam logic [PHASE_W-1:0] PHASE_DONE  = 3'd4;

  typedef enum logic [PHASE_W-1:0] {
    ST_IDLE  = PHASE_IDLE,
    ST_LOAD  = PHASE_LOAD,
    ST_RUN   = PHASE_RUN,
    ST_DRAIN = PHASE_DRAIN,
    ST_DONE  = PHASE_DONE
  } phase_e;
endpackage

// File: rtl/dram_phase_sequencer_if.sv
// Bundle of UART, processor, TX and DRAM signals owned by the phase sequencer.
interface dram_phase_sequencer_if
  import dram_seq_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              clear;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic [ADDR_W-1:0] proc_addr;
  logic [DATA_W-1:0] proc_wdata;
  logic              proc_we;
  logic              proc_done;
  logic              proc_enable;
  logic [DATA_W-1:0] proc_rdata;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [PHASE_W-1:0] phase;
  logic              load_done;
  logic              dump_done;
  logic              rx_overrun;
  logic [ADDR_W:0]   byte_count;

  modport master (
    input  clear, rx_valid, rx_data, proc_addr, proc_wdata, proc_we, proc_done,
           tx_ready, mem_rdata,
    output proc_enable, proc_rdata, tx_valid, tx_data, mem_addr, mem_wdata, mem_we,
           phase, load_done, dump_done, rx_overrun, byte_count
  );

  modport slave (
    output clear, rx_valid, rx_data, proc_addr, proc_wdata, proc_we, proc_done,
           tx_ready, mem_rdata,
    input  proc_enable, proc_rdata, tx_valid, tx_data, mem_addr, mem_wdata, mem_we,
           phase, load_done, dump_done, rx_overrun, byte_count
  );
endinterface

// File: rtl/dram_phase_sequencer_dump_reader.sv
// DRAIN engine: walks the dump window, waits out the DRAM read latency and
// holds each byte on a valid/ready port until the transmitter takes it.
module dram_dump_reader #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int DUMP_BASE  = 0,
  parameter int DUMP_BYTES = 16384,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              active,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic [ADDR_W:0]   cnt,
  output logic              last
);
  localparam int CNT_W = ADDR_W + 1;

  // bit k set means the read issued k+1 cycles ago is still in flight
  logic [RD_LAT-1:0] vld_pipe;
  logic [CNT_W-1:0]  cnt_q;
  logic              tx_valid_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              issue, hs;

  assign hs    = tx_valid_q & tx_ready;
  assign issue = active & ~tx_valid_q & ~(|vld_pipe) & (cnt_q != CNT_W'(DUMP_BYTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else if (clear) begin
      vld_pipe   <= '0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | RD_LAT'(issue);
      if (vld_pipe[RD_LAT-1]) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= mem_rdata;
      end else if (hs) begin
        tx_valid_q <= 1'b0;
        cnt_q      <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign rd_addr  = ADDR_W'(DUMP_BASE) + cnt_q[ADDR_W-1:0];
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign cnt      = cnt_q;
  assign last     = hs & (cnt_q == CNT_W'(DUMP_BYTES - 1));
endmodule

// File: rtl/dram_phase_sequencer.sv
// Owner of the shared single-port DRAM: LOAD from UART, RUN the processor,
// DRAIN results to the UART transmitter, then park in DONE until cleared.
module dram_phase_sequencer
  import dram_seq_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int LOAD_BASE  = 0,
  parameter int LOAD_BYTES = 65536,
  parameter int DUMP_BASE  = 0,
  parameter int DUMP_BYTES = 16384,
  parameter int RD_LAT     = 1
) (
  input  logic clk,
  input  logic rst_n,
  dram_phase_sequencer_if.master bus
);
  localparam int CNT_W = ADDR_W + 1;

  if (LOAD_BYTES < 1 ||
      longint'(LOAD_BASE) + longint'(LOAD_BYTES) > (longint'(1) << ADDR_W)) begin : g_bad_load
    $error("dram_phase_sequencer: LOAD window outside DRAM");
  end
  if (DUMP_BYTES < 1 ||
      longint'(DUMP_BASE) + longint'(DUMP_BYTES) > (longint'(1) << ADDR_W)) begin : g_bad_dump
    $error("dram_phase_sequencer: DUMP window outside DRAM");
  end
  if (RD_LAT < 1) begin : g_bad_lat
    $error("dram_phase_sequencer: RD_LAT must be at least 1");
  end

  phase_e           state, state_nxt;
  logic [CNT_W-1:0] ld_cnt, ld_cnt_nxt;
  logic             proc_en_q, proc_en_nxt;
  logic             load_done_q, load_done_nxt;
  logic             dump_done_q, dump_done_nxt;
  logic             overrun_q, overrun_nxt;
  logic             ld_last;

  logic              rd_active, rd_last, rd_tx_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_tx_data;
  logic [CNT_W-1:0]  rd_cnt;

  assign ld_last   = ld_cnt == CNT_W'(LOAD_BYTES - 1);
  assign rd_active = state == ST_DRAIN;

  dram_dump_reader #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DUMP_BASE (DUMP_BASE),
    .DUMP_BYTES(DUMP_BYTES),
    .RD_LAT    (RD_LAT)
  ) u_reader (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (bus.clear),
    .active   (rd_active),
    .tx_ready (bus.tx_ready),
    .mem_rdata(bus.mem_rdata),
    .rd_addr  (rd_addr),
    .tx_valid (rd_tx_valid),
    .tx_data  (rd_tx_data),
    .cnt      (rd_cnt),
    .last     (rd_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ld_cnt      <= '0;
      proc_en_q   <= 1'b0;
      load_done_q <= 1'b0;
      dump_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      ld_cnt      <= ld_cnt_nxt;
      proc_en_q   <= proc_en_nxt;
      load_done_q <= load_done_nxt;
      dump_done_q <= dump_done_nxt;
      overrun_q   <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ld_cnt_nxt    = ld_cnt;
    proc_en_nxt   = proc_en_q;
    load_done_nxt = 1'b0;
    dump_done_nxt = 1'b0;
    overrun_nxt   = overrun_q;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;

    unique case (state)
      ST_IDLE, ST_LOAD: begin
        if (bus.rx_valid || state == ST_LOAD) begin
          bus.mem_addr  = ADDR_W'(LOAD_BASE) + ld_cnt[ADDR_W-1:0];
          bus.mem_wdata = bus.rx_data;
        end
        if (bus.rx_valid) begin
          bus.mem_we = 1'b1;
          if (ld_last) begin
            state_nxt     = ST_RUN;
            ld_cnt_nxt    = '0;
            load_done_nxt = 1'b1;
            proc_en_nxt   = 1'b1;
          end else begin
            state_nxt  = ST_LOAD;
            ld_cnt_nxt = ld_cnt + CNT_W'(1);
          end
        end
      end
      ST_RUN: begin
        bus.mem_addr  = bus.proc_addr;
        bus.mem_wdata = bus.proc_wdata;
        bus.mem_we    = bus.proc_we;
        // load_done is high only in the first RUN cycle, where proc_done may be stale
        if (bus.proc_done && !load_done_q) begin
          state_nxt   = ST_DRAIN;
          proc_en_nxt = 1'b0;
        end
      end
      ST_DRAIN: begin
        bus.mem_addr = rd_addr;
        if (rd_last) begin
          state_nxt     = ST_DONE;
          dump_done_nxt = 1'b1;
        end
      end
      ST_DONE: ;
      default: state_nxt = ST_IDLE;
    endcase

    if (bus.rx_valid && (state inside {ST_RUN, ST_DRAIN, ST_DONE}))
      overrun_nxt = 1'b1;

    if (bus.clear) begin
      state_nxt     = ST_IDLE;
      ld_cnt_nxt    = '0;
      proc_en_nxt   = 1'b0;
      load_done_nxt = 1'b0;
      dump_done_nxt = 1'b0;
      overrun_nxt   = 1'b0;
      bus.mem_we    = 1'b0;
    end
    // a write must not slip through while reset is being asserted
    if (!rst_n) bus.mem_we = 1'b0;
  end

  assign bus.phase       = state;
  assign bus.proc_enable = proc_en_q;
  assign bus.proc_rdata  = bus.mem_rdata;
  assign bus.tx_valid    = rd_tx_valid;
  assign bus.tx_data     = rd_tx_data;
  assign bus.load_done   = load_done_q;
  assign bus.dump_done   = dump_done_q;
  assign bus.rx_overrun  = overrun_q;
  assign bus.byte_count  = (state == ST_DRAIN || state == ST_DONE) ? rd_cnt : ld_cnt;
endmodule

// File: tb/tb_dram_phase_sequencer.sv
// Directed bench: LOAD 4 bytes, RUN, DRAIN 3 bytes with stall, clear mid-DRAIN, reset mid-LOAD.
module tb_dram_phase_sequencer;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  dram_phase_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  dram_phase_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_BASE(0), .LOAD_BYTES(4),
    .DUMP_BASE(1), .DUMP_BYTES(3), .RD_LAT(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DRAM model with a two-cycle pipelined read
  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] rd1, rd2;
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    rd1 <= mem[bus.mem_addr];
    rd2 <= rd1;
  end
  assign bus.mem_rdata = rd2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tx(output int n);
    n = 0;
    while (!bus.tx_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int w;
    logic [7:0] a [4];
    logic [7:0] b [4];
    a[0] = 8'hA1; a[1] = 8'hA2; a[2] = 8'hA3; a[3] = 8'hA4;
    b[0] = 8'hB1; b[1] = 8'hB2; b[2] = 8'hB3; b[3] = 8'hB4;

    rst_n = 1'b0;
    bus.clear = 0; bus.rx_valid = 0; bus.rx_data = '0;
    bus.proc_addr = '0; bus.proc_wdata = '0; bus.proc_we = 0; bus.proc_done = 0;
    bus.tx_ready = 0;
    #1;
    check("rst_phase", bus.phase, 0);
    check("rst_outs", {bus.proc_enable, bus.tx_valid, bus.mem_we, bus.load_done,
                       bus.dump_done, bus.rx_overrun}, 0);
    check("rst_count", bus.byte_count, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // LOAD four bytes
    for (int i = 0; i < 4; i++) begin
      bus.rx_valid = 1; bus.rx_data = a[i];
      #1;
      check("load_we", bus.mem_we, 1);
      check("load_addr", bus.mem_addr, i);
      check("load_wdata", bus.mem_wdata, a[i]);
      tick();
      bus.rx_valid = 0;
      if (i < 3) begin
        check("load_phase", bus.phase, 1);
        check("load_count", bus.byte_count, i + 1);
      end
    end
    check("run_phase", bus.phase, 2);
    check("load_done", bus.load_done, 1);
    check("proc_en", bus.proc_enable, 1);
    check("run_count", bus.byte_count, 0);
    for (int i = 0; i < 4; i++) check("mem_loaded", mem[i], a[i]);

    // first RUN cycle: proc_done ignored, processor write mirrored
    bus.proc_done = 1; bus.proc_we = 1; bus.proc_addr = 8'h10; bus.proc_wdata = 8'h5A;
    #1;
    check("run_we", bus.mem_we, 1);
    check("run_addr", bus.mem_addr, 8'h10);
    check("run_wdata", bus.mem_wdata, 8'h5A);
    tick();
    check("run_first_ignore", bus.phase, 2);
    check("load_done_pulse", bus.load_done, 0);
    check("mem_proc", mem[8'h10], 8'h5A);

    // rx_valid during RUN: dropped, overrun sticky
    bus.proc_done = 0; bus.proc_we = 0; bus.rx_valid = 1; bus.rx_data = 8'hEE;
    #1;
    check("run_rx_we", bus.mem_we, 0);
    tick();
    bus.rx_valid = 0;
    check("overrun", bus.rx_overrun, 1);
    check("proc_rdata", bus.proc_rdata, rd2);

    bus.proc_done = 1; bus.tx_ready = 1;
    tick();
    bus.proc_done = 0;
    check("drain_phase", bus.phase, 3);
    check("proc_en_off", bus.proc_enable, 0);
    check("drain_we", bus.mem_we, 0);

    // DRAIN byte 0, ready high
    wait_tx(w);
    check("lat0", w, 3);
    check("tx0", bus.tx_data, a[1]);
    tick();
    check("hs0_valid", bus.tx_valid, 0);
    check("hs0_count", bus.byte_count, 1);

    // byte 1, stalled five cycles
    bus.tx_ready = 0;
    wait_tx(w);
    check("lat1", w, 3);
    check("tx1", bus.tx_data, a[2]);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", bus.tx_valid, 1);
      check("stall_data", bus.tx_data, a[2]);
    end
    bus.tx_ready = 1;
    tick();
    check("hs1_count", bus.byte_count, 2);

    // byte 2 with ready held: handshake RD_LAT+2 cycles after previous one
    wait_tx(w);
    check("spacing", w + 1, 4);
    check("tx2", bus.tx_data, a[3]);
    tick();
    check("done_phase", bus.phase, 4);
    check("dump_done", bus.dump_done, 1);
    check("done_count", bus.byte_count, 3);
    check("done_valid", bus.tx_valid, 0);
    tick();
    check("dump_done_pulse", bus.dump_done, 0);
    check("done_stay", bus.phase, 4);

    bus.clear = 1;
    tick();
    bus.clear = 0; bus.tx_ready = 0;
    check("clr_phase", bus.phase, 0);
    check("clr_overrun", bus.rx_overrun, 0);
    check("clr_count", bus.byte_count, 0);

    // second pass, then clear while a byte is waiting
    for (int i = 0; i < 4; i++) begin
      bus.rx_valid = 1; bus.rx_data = b[i];
      tick();
    end
    bus.rx_valid = 0;
    check("p2_run", bus.phase, 2);
    bus.proc_done = 1;
    tick(); tick();
    bus.proc_done = 0;
    check("p2_drain", bus.phase, 3);
    wait_tx(w);
    check("p2_tx", bus.tx_data, b[1]);
    bus.clear = 1; bus.rx_valid = 1; bus.rx_data = 8'h99; bus.tx_ready = 1;
    #1;
    check("clr_we", bus.mem_we, 0);
    tick();
    bus.clear = 0; bus.rx_valid = 0; bus.tx_ready = 0;
    check("clr2_phase", bus.phase, 0);
    check("clr2_valid", bus.tx_valid, 0);
    check("clr2_overrun", bus.rx_overrun, 0);
    check("clr2_mem", mem[0], b[0]);

    // reset pulse mid-LOAD
    bus.rx_valid = 1; bus.rx_data = 8'h31;
    tick();
    check("p3_load", bus.phase, 1);
    bus.rx_data = 8'h32;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_phase", bus.phase, 0);
    check("arst_outs", {bus.proc_enable, bus.tx_valid, bus.mem_we, bus.load_done,
                        bus.dump_done, bus.rx_overrun}, 0);
    check("arst_count", bus.byte_count, 0);
    tick();
    check("arst_nowrite", mem[1], b[1]);
    bus.rx_valid = 0;
    rst_n = 1'b1;
    tick();
    check("post_rst_phase", bus.phase, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
